// File: rtl/sample_iterator_pkg.sv
// sample_iterator_pkg
//   Shared types and helpers for the rasterizer sample iterator and the
//   downstream raster blocks.
//   - state_t          : iterator FSM state (WAIT = idle/ready, TEST = iterating)
//   - step_shift()     : decodes the one-hot subSample code into the right-shift
//                        applied to 1<<RADIX (1px=0, 1/2=1, 1/4=2, 1/8=3)
package sample_iterator_pkg;

  typedef enum logic {
    WAIT = 1'b0,
    TEST = 1'b1
  } state_t;

  // Non-one-hot codes fall back to a full-pixel step.
  function automatic int step_shift(input logic [3:0] sub);
    case (sub)
      4'b1000: step_shift = 0;
      4'b0100: step_shift = 1;
      4'b0010: step_shift = 2;
      4'b0001: step_shift = 3;
      default: step_shift = 0;
    endcase
  endfunction

endpackage

// File: rtl/sample_iterator_if.sv
// sample_iterator_if
//   Bundles the triangle input bus, the stall handshake and the sample output
//   bus of the sample iterator.
//   slave  : iterator side (consumes triangle/box, produces samples)
//   master : upstream/downstream environment side
//   Signals:
//     tri_R13S[VERTS][AXIS], color_R13U[COLORS], box_R13S[2][2] (LL, UR; x, y)
//     validTri_R13H, subSample_RnnnnU (one-hot step), halt_RnnnnH (downstream stall)
//     halt_R13H (upstream stall), tri_R14S, color_R14U, sample_R14S[2], validSamp_R14H
interface sample_iterator_if #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
);

  logic signed [SIGFIG-1:0] tri_R13S   [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R13U [COLORS];
  logic signed [SIGFIG-1:0] box_R13S   [2][2];
  logic                     validTri_R13H;
  logic        [3:0]        subSample_RnnnnU;
  logic                     halt_RnnnnH;

  logic                     halt_R13H;
  logic signed [SIGFIG-1:0] tri_R14S    [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R14U  [COLORS];
  logic signed [SIGFIG-1:0] sample_R14S [2];
  logic                     validSamp_R14H;

  modport slave (
    input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU, halt_RnnnnH,
    output halt_R13H, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );

  modport master (
    output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU, halt_RnnnnH,
    input  halt_R13H, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );

endinterface

// File: rtl/sample_iterator.sv
// sample_iterator
//   Walks every step-aligned sample point inside a triangle's bounding box in
//   raster order (x fastest, then y), one sample per unstalled cycle.
//   Ports:
//     clk  : clock
//     rst  : synchronous active-high reset
//     bus  : sample_iterator_if.slave (triangle/box in, samples out, stalls)
//   A triangle is accepted in WAIT when validTri_R13H=1 and halt_RnnnnH=0;
//   halt_R13H is high for the whole TEST phase. halt_RnnnnH freezes all state.
module sample_iterator
  import sample_iterator_pkg::*;
#(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic              clk,
  input  logic              rst,
  sample_iterator_if.slave  bus
);

  localparam logic signed [SIGFIG-1:0] ONE = SIGFIG'(1);

  state_t                   r_state;
  logic signed [SIGFIG-1:0] r_tri    [VERTS][AXIS];
  logic        [SIGFIG-1:0] r_color  [COLORS];
  logic signed [SIGFIG-1:0] r_ll     [2];
  logic signed [SIGFIG-1:0] r_ur     [2];
  logic signed [SIGFIG-1:0] r_step;
  logic signed [SIGFIG-1:0] r_sample [2];
  logic                     r_valid;

  state_t                   w_state;
  logic signed [SIGFIG-1:0] w_tri    [VERTS][AXIS];
  logic        [SIGFIG-1:0] w_color  [COLORS];
  logic signed [SIGFIG-1:0] w_ll     [2];
  logic signed [SIGFIG-1:0] w_ur     [2];
  logic signed [SIGFIG-1:0] w_step;
  logic signed [SIGFIG-1:0] w_sample [2];
  logic                     w_valid;
  logic signed [SIGFIG-1:0] w_x_inc;
  logic signed [SIGFIG-1:0] w_y_inc;
  logic                     w_last;

  assign w_x_inc = r_sample[0] + r_step;
  assign w_y_inc = r_sample[1] + r_step;
  assign w_last  = (r_sample[0] == r_ur[0]) && (r_sample[1] == r_ur[1]);

  always_comb begin
    w_state  = r_state;
    w_tri    = r_tri;
    w_color  = r_color;
    w_ll     = r_ll;
    w_ur     = r_ur;
    w_step   = r_step;
    w_sample = r_sample;
    w_valid  = r_valid;

    if (!bus.halt_RnnnnH) begin
      case (r_state)
        WAIT: begin
          if (bus.validTri_R13H) begin
            w_state     = TEST;
            w_tri       = bus.tri_R13S;
            w_color     = bus.color_R13U;
            w_ll        = bus.box_R13S[0];
            w_ur        = bus.box_R13S[1];
            w_step      = ONE <<< (RADIX - step_shift(bus.subSample_RnnnnU));
            // First sample is the LL corner, visible the cycle after acceptance.
            w_sample[0] = bus.box_R13S[0][0];
            w_sample[1] = bus.box_R13S[0][1];
            w_valid     = 1'b1;
          end
        end
        TEST: begin
          if (w_last) begin
            w_state = WAIT;
            w_valid = 1'b0;
          end else if (w_x_inc <= r_ur[0]) begin
            w_sample[0] = w_x_inc;
          end else begin
            w_sample[0] = r_ll[0];
            w_sample[1] = w_y_inc;
          end
        end
        default: begin
          w_state = WAIT;
          w_valid = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WAIT;
      r_valid <= 1'b0;
      r_step  <= '0;
      for (int unsigned v = 0; v < VERTS; v++)
        for (int unsigned a = 0; a < AXIS; a++)
          r_tri[v][a] <= '0;
      for (int unsigned c = 0; c < COLORS; c++)
        r_color[c] <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_ll[i]     <= '0;
        r_ur[i]     <= '0;
        r_sample[i] <= '0;
      end
    end else begin
      r_state  <= w_state;
      r_valid  <= w_valid;
      r_step   <= w_step;
      r_tri    <= w_tri;
      r_color  <= w_color;
      r_ll     <= w_ll;
      r_ur     <= w_ur;
      r_sample <= w_sample;
    end
  end

  assign bus.halt_R13H      = (r_state == TEST);
  assign bus.tri_R14S       = r_tri;
  assign bus.color_R14U     = r_color;
  assign bus.sample_R14S    = r_sample;
  assign bus.validSamp_R14H = r_valid;

endmodule
